// File: rtl/shift_sequencer.sv
// shift_sequencer: two-requester, round-robin shift unit built around one
// shared left shifter and one shared right shifter. ASR and ROR take a
// second pass (FIX) through the shared shifters to merge in sign fill or
// wrapped-around bits.
// Optional feature: define SHIFT_SEQ_ZERO_BYPASS_EN to let mag=0 requests
// skip EXEC/FIX and respond directly from IDLE.

module leftshifter16bit (
    input  logic [15:0] in_i,
    input  logic [3:0]  sh_i,
    output logic [15:0] out_o
);
    assign out_o = in_i << sh_i;
endmodule

module rightshifter16bit (
    input  logic [15:0] in_i,
    input  logic [3:0]  sh_i,
    output logic [15:0] out_o
);
    assign out_o = in_i >> sh_i;
endmodule

module shift_sequencer (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req0_valid,
    output logic        req0_ready,
    input  logic [1:0]  req0_op,
    input  logic [15:0] req0_data,
    input  logic [3:0]  req0_mag,
    input  logic        req1_valid,
    output logic        req1_ready,
    input  logic [1:0]  req1_op,
    input  logic [15:0] req1_data,
    input  logic [3:0]  req1_mag,
    output logic        resp_valid,
    input  logic        resp_ready,
    output logic        resp_id,
    output logic [15:0] resp_data,
    output logic        resp_carry,
    output logic        busy
);
    typedef enum logic [1:0] {IDLE, EXEC, FIX, RESP} state_t;

    localparam logic [1:0] OP_LSL = 2'b00;
    localparam logic [1:0] OP_LSR = 2'b01;
    localparam logic [1:0] OP_ASR = 2'b10;

    state_t      state_q, state_d;
    logic        last_grant_q, last_grant_d;
    logic [1:0]  op_q, op_d;
    logic [15:0] data_q, data_d;
    logic [3:0]  mag_q, mag_d;
    logic        id_q, id_d;
    logic [15:0] res_q, res_d;
    logic        carry_q, carry_d;

    logic        gnt0, gnt1;
    logic [15:0] l_in, r_in, l_out, r_out;
    logic [3:0]  l_sh, r_sh;
    logic [3:0]  lsl_idx, rsh_idx;
    logic [15:0] ror_res;
    logic [1:0]  acc_op;
    logic [15:0] acc_data;
    logic [3:0]  acc_mag;

    leftshifter16bit u_lsh (.in_i(l_in), .sh_i(l_sh), .out_o(l_out));
    rightshifter16bit u_rsh (.in_i(r_in), .sh_i(r_sh), .out_o(r_out));

    // Round-robin grant; ready is only offered in IDLE and never while in reset.
    always_comb begin
        gnt0 = 1'b0;
        gnt1 = 1'b0;
        if (state_q == IDLE && rst_n) begin
            if (req0_valid && (!req1_valid || last_grant_q))
                gnt0 = 1'b1;
            else if (req1_valid)
                gnt1 = 1'b1;
        end
    end

    assign req0_ready = gnt0;
    assign req1_ready = gnt1;
    assign acc_op     = gnt1 ? req1_op   : req0_op;
    assign acc_data   = gnt1 ? req1_data : req0_data;
    assign acc_mag    = gnt1 ? req1_mag  : req0_mag;

    // Shared shifter feeds: first pass shifts the operand, FIX pass builds
    // the sign mask (right) or the wrapped part of a rotate (left, 16-mag).
    always_comb begin
        l_in = data_q;
        l_sh = mag_q;
        r_in = data_q;
        r_sh = mag_q;
        if (state_q == FIX) begin
            l_sh = 4'd0 - mag_q;
            r_in = 16'hFFFF;
        end
    end

    // Bit positions of the last bit shifted out (valid only for mag > 0).
    assign lsl_idx = 4'd0 - mag_q;
    assign rsh_idx = mag_q - 4'd1;
    assign ror_res = res_q | l_out;

    // Next-state and datapath update logic.
    always_comb begin
        state_d      = state_q;
        last_grant_d = last_grant_q;
        op_d         = op_q;
        data_d       = data_q;
        mag_d        = mag_q;
        id_d         = id_q;
        res_d        = res_q;
        carry_d      = carry_q;
        case (state_q)
            IDLE: begin
                if (gnt0 || gnt1) begin
                    op_d         = acc_op;
                    data_d       = acc_data;
                    mag_d        = acc_mag;
                    id_d         = gnt1;
                    last_grant_d = gnt1;
                    state_d      = EXEC;
`ifdef SHIFT_SEQ_ZERO_BYPASS_EN
                    if (acc_mag == 4'd0) begin
                        res_d   = acc_data;
                        carry_d = 1'b0;
                        state_d = RESP;
                    end
`endif
                end
            end
            EXEC: begin
                if (op_q == OP_LSL) begin
                    res_d   = l_out;
                    carry_d = (mag_q == 4'd0) ? 1'b0 : data_q[lsl_idx];
                    state_d = RESP;
                end else begin
                    res_d   = r_out;
                    carry_d = (mag_q == 4'd0) ? 1'b0 : data_q[rsh_idx];
                    state_d = (op_q == OP_LSR) ? RESP : FIX;
                end
            end
            FIX: begin
                if (op_q == OP_ASR) begin
                    res_d = res_q | (data_q[15] ? ~r_out : 16'h0000);
                end else begin
                    res_d   = ror_res;
                    carry_d = (mag_q == 4'd0) ? 1'b0 : ror_res[15];
                end
                state_d = RESP;
            end
            RESP: begin
                if (resp_ready)
                    state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // State and datapath registers, all cleared by asynchronous reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            last_grant_q <= 1'b1;
            op_q         <= 2'b00;
            data_q       <= 16'h0000;
            mag_q        <= 4'd0;
            id_q         <= 1'b0;
            res_q        <= 16'h0000;
            carry_q      <= 1'b0;
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
            op_q         <= op_d;
            data_q       <= data_d;
            mag_q        <= mag_d;
            id_q         <= id_d;
            res_q        <= res_d;
            carry_q      <= carry_d;
        end
    end

    assign resp_valid = (state_q == RESP);
    assign busy       = (state_q != IDLE);
    assign resp_id    = id_q;
    assign resp_data  = res_q;
    assign resp_carry = carry_q;
endmodule

// File: tb/tb_shift_sequencer.sv
// Self-checking bench for shift_sequencer: directed cases plus random
// traffic compared against an arithmetic reference model.
module tb_shift_sequencer;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        req0_valid = 1'b0, req1_valid = 1'b0;
    logic        req0_ready, req1_ready;
    logic [1:0]  req0_op = 2'b00, req1_op = 2'b00;
    logic [15:0] req0_data = 16'h0, req1_data = 16'h0;
    logic [3:0]  req0_mag = 4'd0, req1_mag = 4'd0;
    logic        resp_valid, resp_id, resp_carry, busy;
    logic        resp_ready = 1'b0;
    logic [15:0] resp_data;

    int total = 0;
    int bad = 0;
    int mlast = 1;

    shift_sequencer dut (
        .clk(clk), .rst_n(rst_n),
        .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_op(req0_op),
        .req0_data(req0_data), .req0_mag(req0_mag),
        .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_op(req1_op),
        .req1_data(req1_data), .req1_mag(req1_mag),
        .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_id(resp_id),
        .resp_data(resp_data), .resp_carry(resp_carry), .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Reference: shift results straight from the operator definitions.
    function automatic logic [16:0] model(input logic [1:0] op, input logic [15:0] d, input int m);
        logic [15:0] r;
        logic        c;
        int          dv;
        dv = int'(d);
        case (op)
            2'b00:   r = 16'((dv << m) & 32'hFFFF);
            2'b01:   r = 16'(dv >> m);
            2'b10:   r = 16'($signed(d) >>> m);
            default: r = 16'(((dv >> m) | (dv << (16 - m))) & 32'hFFFF);
        endcase
        if (m == 0)          c = 1'b0;
        else if (op == 2'b00) c = d[16 - m];
        else if (op == 2'b11) c = r[15];
        else                 c = d[m - 1];
        return {c, r};
    endfunction

    function automatic int exp_lat(input logic [1:0] op, input int m);
`ifdef SHIFT_SEQ_ZERO_BYPASS_EN
        if (m == 0) return 1;
`endif
        return (op == 2'b00 || op == 2'b01) ? 2 : 3;
    endfunction

    // One transaction: present requests, check grant, wait for response,
    // optionally stall the response, then handshake.
    task automatic txn(input bit v0, input logic [1:0] o0, input logic [15:0] d0, input logic [3:0] m0,
                       input bit v1, input logic [1:0] o1, input logic [15:0] d1, input logic [3:0] m1,
                       input bit keep, input int hold);
        int          win, lat;
        logic [1:0]  op;
        logic [15:0] d;
        logic [3:0]  m;
        logic [16:0] e;
        logic [15:0] sd;
        logic        sc, si;
        req0_valid = v0; req0_op = o0; req0_data = d0; req0_mag = m0;
        req1_valid = v1; req1_op = o1; req1_data = d1; req1_mag = m1;
        if (v0 && v1) win = 1 - mlast;
        else          win = v1 ? 1 : 0;
        #1;
        chk("ready0", req0_ready, win == 0);
        chk("ready1", req1_ready, win == 1);
        mlast = win;
        op = win ? o1 : o0;
        d  = win ? d1 : d0;
        m  = win ? m1 : m0;
        e  = model(op, d, int'(m));
        @(posedge clk); #1;
        if (!keep) begin req0_valid = 1'b0; req1_valid = 1'b0; end
        lat = 1;
        while (!resp_valid && lat < 8) begin
            @(posedge clk); #1;
            lat++;
        end
        chk("latency", lat, exp_lat(op, int'(m)));
        chk("resp_data", resp_data, e[15:0]);
        chk("resp_carry", resp_carry, e[16]);
        chk("resp_id", resp_id, win);
        chk("busy_resp", busy, 1);
        sd = resp_data; sc = resp_carry; si = resp_id;
        for (int k = 0; k < hold; k++) begin
            @(posedge clk); #1;
            chk("hold_valid", resp_valid, 1);
            chk("hold_data", resp_data, sd);
            chk("hold_carry", resp_carry, sc);
            chk("hold_id", resp_id, si);
            chk("hold_rdy", {req0_ready, req1_ready}, 2'b00);
            chk("hold_busy", busy, 1);
        end
        resp_ready = 1'b1;
        @(posedge clk); #1;
        resp_ready = 1'b0;
        chk("resp_drop", resp_valid, 0);
        chk("idle_busy", busy, 0);
    endtask

    initial begin
        // Reset state with requests pending.
        req0_valid = 1'b1; req1_valid = 1'b1;
        #12;
        chk("rst_ready", {req0_ready, req1_ready}, 2'b00);
        chk("rst_outs", {resp_valid, resp_id, resp_carry, busy, resp_data}, 20'h0);
        req0_valid = 1'b0; req1_valid = 1'b0;
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk); #1;
        mlast = 1;

        // Directed examples.
        txn(1, 2'b00, 16'h00F1, 4'd4, 0, 2'b00, 16'h0, 4'd0, 0, 0);
        txn(0, 2'b00, 16'h0, 4'd0, 1, 2'b10, 16'h8000, 4'd3, 0, 0);
        txn(1, 2'b01, 16'h8001, 4'd1, 0, 2'b00, 16'h0, 4'd0, 0, 0);
        txn(1, 2'b11, 16'h0001, 4'd1, 0, 2'b00, 16'h0, 4'd0, 0, 0);
        txn(0, 2'b00, 16'h0, 4'd0, 1, 2'b11, 16'h1234, 4'd0, 0, 0);
        txn(1, 2'b10, 16'h7FF0, 4'd15, 0, 2'b00, 16'h0, 4'd0, 0, 0);
        txn(1, 2'b00, 16'hABCD, 4'd0, 0, 2'b00, 16'h0, 4'd0, 0, 0);

        // Stalled response with both requesters waiting.
        txn(1, 2'b10, 16'hC003, 4'd2, 1, 2'b01, 16'h5555, 4'd7, 1, 5);

        // Fresh reset, then continuous contention: grants must alternate.
        req0_valid = 1'b0; req1_valid = 1'b0;
        rst_n = 1'b0; #2; rst_n = 1'b1;
        mlast = 1;
        @(posedge clk); #1;
        for (int i = 0; i < 4; i++)
            txn(1, 2'b00, 16'h0101, 4'd1, 1, 2'b11, 16'h8421, 4'd5, 1, 0);
        req0_valid = 1'b0; req1_valid = 1'b0;
        @(posedge clk); #1;

        // Reset pulse during FIX discards the operation.
        req1_valid = 1'b1; req1_op = 2'b10; req1_data = 16'h9999; req1_mag = 4'd4;
        @(posedge clk); #1;
        req1_valid = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b0; #1;
        req0_valid = 1'b1;
        #1;
        chk("midrst_outs", {resp_valid, resp_id, resp_carry, busy, resp_data}, 20'h0);
        chk("midrst_rdy", {req0_ready, req1_ready}, 2'b00);
        req0_valid = 1'b0;
        rst_n = 1'b1;
        mlast = 1;
        for (int k = 0; k < 4; k++) begin
            @(posedge clk); #1;
            chk("midrst_noresp", resp_valid, 0);
        end
        txn(1, 2'b11, 16'hF00F, 4'd12, 0, 2'b00, 16'h0, 4'd0, 0, 0);

        // Random traffic.
        for (int i = 0; i < 40; i++) begin
            bit v0, v1;
            v0 = 1'($urandom_range(0, 1));
            v1 = 1'($urandom_range(0, 1));
            if (!v0 && !v1) v0 = 1'b1;
            txn(v0, 2'($urandom), 16'($urandom), 4'($urandom),
                v1, 2'($urandom), 16'($urandom), 4'($urandom),
                0, int'($urandom_range(0, 2)));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
